// File: rtl/rand_pkg.sv
// Shared state type, LFSR constants and step function for rand_request_arbiter.
package rand_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam int                MAX_TRIES = 8;

    // Right-shifting Galois LFSR: the bit shifted out selects the tap XOR.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/rand_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, circularly.
module rand_rr_pick
    import rand_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_req
);

    logic [N_REQ-1:0] rot;
    logic [PTR_W-1:0] first;
    logic [PTR_W:0]   sum;

    // Rotate so rr_ptr lands on bit 0, find lowest set bit, then rotate the index back.
    always_comb begin
        rot   = N_REQ'({req, req} >> rr_ptr);
        first = '0;
        for (int unsigned j = N_REQ; j > 0; j--) begin
            if (rot[j-1]) first = PTR_W'(j - 1);
        end
        sum = {1'b0, rr_ptr} + {1'b0, first};
        if (sum >= (PTR_W+1)'(N_REQ)) grant_idx = PTR_W'(sum - (PTR_W+1)'(N_REQ));
        else                          grant_idx = sum[PTR_W-1:0];
        any_req = |req;
    end

endmodule

// File: rtl/rand_request_arbiter.sv
// Round-robin arbiter handing out bounded random values to N_REQ requesters.
// Source is a wrap counter by default; define RAND_LFSR_EN for a 16-bit Galois LFSR with rejection.
module rand_request_arbiter
    import rand_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter int          SIZE_BITS = 9,
    parameter int          MIN_VAL   = 0,
    parameter int          MAX_VAL   = 479,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     ack,
    output logic [SIZE_BITS-1:0] dout,
    output logic                 busy
);

    localparam int                   PTR_W    = $clog2(N_REQ);
    localparam int                   RANGE    = MAX_VAL - MIN_VAL + 1;
    localparam logic [SIZE_BITS:0]   RANGE_W  = (SIZE_BITS+1)'(RANGE);
    localparam logic [SIZE_BITS-1:0] MIN_W    = SIZE_BITS'(MIN_VAL);
    localparam logic [LFSR_W-1:0]    SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    if (N_REQ < 2 || N_REQ > 8 || RANGE <= (1 << (SIZE_BITS-1)) || RANGE > (1 << SIZE_BITS)
        || SEED_EFF == '0) begin : g_cfg_check
        $error("rand_request_arbiter: illegal parameter set");
    end

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     grant_idx, grant_nxt;
    logic [PTR_W-1:0]     rr_ptr, rr_nxt;
    logic [PTR_W-1:0]     pick_idx;
    logic                 any_req;
    logic [N_REQ-1:0]     ack_nxt;
    logic [SIZE_BITS-1:0] dout_nxt;
    logic [SIZE_BITS-1:0] sample;
    logic                 accept;

    rand_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

`ifdef RAND_LFSR_EN
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [LFSR_W-1:0]    lfsr;
    logic [TRY_W-1:0]     tries, tries_nxt;
    logic [SIZE_BITS-1:0] cand;
    logic                 in_range;

    assign cand     = lfsr[SIZE_BITS-1:0];
    assign in_range = ({1'b0, cand} < RANGE_W);
    // After MAX_TRIES rejections the folded candidate is taken; cand < 2*RANGE keeps it in range.
    assign accept   = in_range || (tries == TRY_W'(MAX_TRIES));
    assign sample   = in_range ? cand : SIZE_BITS'({1'b0, cand} - RANGE_W);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lfsr  <= SEED_EFF;
            tries <= '0;
        end else begin
            lfsr  <= lfsr_step(lfsr);
            tries <= tries_nxt;
        end
    end
`else
    logic [SIZE_BITS-1:0] counter;

    assign accept = 1'b1;
    assign sample = counter;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)                                    counter <= '0;
        else if ({1'b0, counter} == RANGE_W - 1'b1)     counter <= '0;
        else                                            counter <= counter + 1'b1;
    end
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_idx;
        rr_nxt    = rr_ptr;
        ack_nxt   = '0;
        dout_nxt  = dout;
`ifdef RAND_LFSR_EN
        tries_nxt = tries;
`endif
        case (state)
            IDLE: begin
`ifdef RAND_LFSR_EN
                tries_nxt = '0;
`endif
                if (any_req) begin
                    grant_nxt = pick_idx;
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                // A dropped request aborts without moving the round-robin pointer.
                if (!req[grant_idx]) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    dout_nxt  = MIN_W + sample;
                    ack_nxt   = N_REQ'(1) << grant_idx;
                    rr_nxt    = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_nxt = DONE;
                end
`ifdef RAND_LFSR_EN
                else begin
                    tries_nxt = tries + 1'b1;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            ack       <= '0;
            dout      <= '0;
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            rr_ptr    <= rr_nxt;
            ack       <= ack_nxt;
            dout      <= dout_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rand_request_arbiter.sv
// Self-checking bench for rand_request_arbiter; reference model covers both source configurations.
`timescale 1ns/1ps
module tb_rand_request_arbiter;

    localparam int N      = 4;
    localparam int BITS   = 9;
    localparam int MINV   = 0;
    localparam int MAXV   = 479;
    localparam int RANGE  = MAXV - MINV + 1;
    localparam int W_MIN  = 10;
    localparam int W_MAX  = 13;
    localparam int W_RANGE = W_MAX - W_MIN + 1;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    ack;
    logic [BITS-1:0] dout;
    logic            busy;
    logic [1:0]      req2 = '0;
    logic [1:0]      ack2;
    logic [1:0]      dout2;
    logic            busy2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned edges    = 0;
    int unsigned mptr     = 0;
    logic [15:0] lfsr_m   = 16'hACE1;
    logic [15:0] hist[$];

    always #5 clk = ~clk;

    rand_request_arbiter #(
        .N_REQ(N), .SIZE_BITS(BITS), .MIN_VAL(MINV), .MAX_VAL(MAXV), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .resetN(resetN), .req(req), .ack(ack), .dout(dout), .busy(busy)
    );

    rand_request_arbiter #(
        .N_REQ(2), .SIZE_BITS(2), .MIN_VAL(W_MIN), .MAX_VAL(W_MAX), .SEED(16'hACE1)
    ) dut_wrap (
        .clk(clk), .resetN(resetN), .req(req2), .ack(ack2), .dout(dout2), .busy(busy2)
    );

    // Source model: number of edges since reset, plus the LFSR value seen before each edge.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            edges  = 0;
            lfsr_m = 16'hACE1;
            hist.delete();
        end else begin
            edges++;
            hist.push_back(lfsr_m);
            lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
        end
    end

    // Value the source offers at edge e (the e-th edge after reset), reduced into [0, range).
    function automatic int unsigned model_sample(input int unsigned e, input int unsigned range,
                                                 input int unsigned bits, output bit ok);
        int unsigned mask;
        int unsigned cand;
        mask = (32'd1 << bits) - 1;
        ok   = 1'b1;
`ifdef RAND_LFSR_EN
        if (e == 0 || e > hist.size()) begin
            ok = 1'b0;
            return 0;
        end
        cand = hist[e-1] & mask;
        if (cand < range) return cand;
        if (e < 9) begin
            ok = 1'b0;
            return cand - range;
        end
        for (int unsigned t = 2; t <= 9; t++) begin
            if ((hist[e-t] & mask) < range) ok = 1'b0;
        end
        return cand - range;
`else
        cand = (e - 1) % range;
        return cand + (mask & 0);
`endif
    endfunction

    function automatic int unsigned model_pick(input logic [N-1:0] r, input int unsigned ptr);
        for (int unsigned i = 0; i < N; i++) begin
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        end
        return 0;
    endfunction

    task automatic do_reset();
        resetN = 1'b0;
        req    = '0;
        req2   = '0;
        mptr   = 0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic wait_ack(output logic [N-1:0] a, output int unsigned e, output bit got);
        got = 1'b0;
        a   = '0;
        e   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack !== '0) begin
                a   = ack;
                e   = edges;
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (ack !== '0)  begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got=%0d exp=0", dout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (ack2 !== '0) begin n_fail++; $display("FAIL reset_ack2 got=%b exp=0", ack2); end
        n_checks++; if (dout2 !== '0) begin n_fail++; $display("FAIL reset_dout2 got=%0d exp=0", dout2); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end
    endtask

    task automatic test_single();
        logic [N-1:0] a;
        int unsigned  e, e0, s;
        bit           got, ok;
        @(negedge clk);
        req = 4'b0001;
        e0  = edges;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || ack !== '0) begin
            n_fail++; $display("FAIL single_draw busy=%b ack=%b exp busy=1 ack=0", busy, ack);
        end
        wait_ack(a, e, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL single_timeout no ack exp ack=0001"); end
`ifdef RAND_LFSR_EN
        n_checks++; if (e < e0 + 2 || e > e0 + 10) begin
            n_fail++; $display("FAIL single_latency ack_edge=%0d exp %0d..%0d", e, e0 + 2, e0 + 10);
        end
`else
        n_checks++; if (e !== e0 + 2) begin
            n_fail++; $display("FAIL single_latency ack_edge=%0d exp=%0d", e, e0 + 2);
        end
`endif
        n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b exp=0001", a); end
        s = model_sample(e, RANGE, BITS, ok);
        n_checks++; if (dout !== BITS'(MINV + s) || !ok) begin
            n_fail++; $display("FAIL single_dout got=%0d exp=%0d model_ok=%0d", dout, MINV + s, ok);
        end
        req  = '0;
        mptr = 1;
        @(negedge clk);
        n_checks++; if (ack !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_pulse ack=%b busy=%b exp ack=0 busy=0", ack, busy);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] a;
        int unsigned  e, prev_e, s, exp_idx;
        bit           got, ok;
        do_reset();
        req    = '1;
        prev_e = 0;
        for (int k = 0; k < N; k++) begin
            exp_idx = model_pick(req, mptr);
            wait_ack(a, e, got);
            n_checks++; if (!got || a !== N'(1) << exp_idx) begin
                n_fail++; $display("FAIL contention_ack[%0d] got=%b exp=%b", k, a, N'(1) << exp_idx);
            end
            s = model_sample(e, RANGE, BITS, ok);
            n_checks++; if (dout !== BITS'(MINV + s) || !ok) begin
                n_fail++; $display("FAIL contention_dout[%0d] got=%0d exp=%0d", k, dout, MINV + s);
            end
`ifndef RAND_LFSR_EN
            if (k > 0) begin
                n_checks++; if (e - prev_e !== 3) begin
                    n_fail++; $display("FAIL contention_gap[%0d] got=%0d exp=3", k, e - prev_e);
                end
            end
`endif
            prev_e = e;
            req    = req & ~a;
            mptr   = (exp_idx + 1) % N;
            if (!got) break;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [N-1:0] a;
        int unsigned  e, exp_idx;
        bit           got;
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_draw busy=%b exp=1", busy); end
        req = '0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || ack !== '0) begin
            n_fail++; $display("FAIL abort_idle busy=%b ack=%b exp busy=0 ack=0", busy, ack);
        end
        req     = 4'b0101;
        exp_idx = model_pick(req, mptr);
        wait_ack(a, e, got);
        n_checks++; if (!got || a !== N'(1) << exp_idx) begin
            n_fail++; $display("FAIL abort_next_grant got=%b exp=%b", a, N'(1) << exp_idx);
        end
        mptr = (exp_idx + 1) % N;
        req  = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int unsigned e, prev_e, s;
        bit          got, ok;
        prev_e = 0;
        req2   = 2'b01;
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (ack2 !== '0) got = 1'b1;
            end
            e = edges;
            n_checks++; if (!got || ack2 !== 2'b01) begin
                n_fail++; $display("FAIL wrap_ack[%0d] got=%b exp=01", k, ack2);
            end
            s = model_sample(e, W_RANGE, 2, ok);
            // Port is 2 bits wide, so the low bits of MIN_VAL+sample are what can be observed.
            n_checks++; if (dout2 !== 2'(W_MIN + s) || !ok) begin
                n_fail++; $display("FAIL wrap_dout[%0d] got=%0d exp=%0d", k, dout2, 2'(W_MIN + s));
            end
`ifndef RAND_LFSR_EN
            if (k > 0) begin
                n_checks++; if (e - prev_e !== 3) begin
                    n_fail++; $display("FAIL wrap_gap[%0d] got=%0d exp=3", k, e - prev_e);
                end
            end
`endif
            prev_e = e;
            if (!got) break;
        end
        req2 = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random(input int unsigned draws);
        logic [N-1:0] a;
        int unsigned  e, s, exp_idx, bad;
        bit           got, ok;
        bad = 0;
        req = N'($urandom);
        if (req == '0) req = 4'b1000;
        for (int unsigned k = 0; k < draws; k++) begin
            exp_idx = model_pick(req, mptr);
            wait_ack(a, e, got);
            n_checks++; if (!got || a !== N'(1) << exp_idx) begin
                n_fail++; $display("FAIL random_ack[%0d] got=%b exp=%b", k, a, N'(1) << exp_idx);
                bad++;
            end
            s = model_sample(e, RANGE, BITS, ok);
            n_checks++; if (dout !== BITS'(MINV + s) || !ok) begin
                n_fail++; $display("FAIL random_dout[%0d] got=%0d exp=%0d", k, dout, MINV + s);
                bad++;
            end
            n_checks++; if (int'(dout) > MAXV || int'(dout) < MINV) begin
                n_fail++; $display("FAIL random_range[%0d] got=%0d exp %0d..%0d", k, dout, MINV, MAXV);
            end
            if (bad > 5) break;
            mptr = (exp_idx + 1) % N;
            req  = (req & ~a) | N'($urandom);
            if (req == '0) req = N'(1) << $urandom_range(N - 1);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] a;
        int unsigned  e;
        bit           got;
        do_reset();
        req = 4'b0001;
        wait_ack(a, e, got);
        req = '0;
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_pre busy=%b exp=1", busy); end
        resetN = 1'b0;
        #1;
        n_checks++; if (ack !== '0 || busy !== 1'b0 || dout !== '0) begin
            n_fail++; $display("FAIL midreset_draw ack=%b busy=%b dout=%0d exp 0/0/0", ack, busy, dout);
        end
        mptr = 0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        wait_ack(a, e, got);
        n_checks++; if (!got || a !== N'(1) << model_pick(4'b0010, mptr)) begin
            n_fail++; $display("FAIL midreset_grant1 got=%b exp=0010", a);
        end
        resetN = 1'b0;
        #1;
        n_checks++; if (ack !== '0 || busy !== 1'b0 || dout !== '0) begin
            n_fail++; $display("FAIL midreset_done ack=%b busy=%b dout=%0d exp 0/0/0", ack, busy, dout);
        end
        mptr = 0;
        req  = 4'b0111;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        wait_ack(a, e, got);
        n_checks++; if (!got || a !== N'(1) << model_pick(req, mptr)) begin
            n_fail++; $display("FAIL midreset_first_grant got=%b exp=%b", a, N'(1) << model_pick(req, mptr));
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_wrap();
`ifdef RAND_LFSR_EN
        test_random(10000);
`else
        test_random(1500);
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
